// File: rtl/i2c_slave_fifo_param.sv
// I2C slave with a configurable 7-bit address, a TX FIFO feeding master reads,
// and a one-cycle strobed receive byte for master writes. Bus pins are oversampled by clk.
module i2c_slave_fifo_param #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'b1111000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          scl,
  input  logic                          sda_in,
  output logic                          sda_out,
  input  logic                          write_enable,
  input  logic [7:0]                    write_data,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic                          tx_underrun,
  output logic                          busy
);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK_CHK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   rw_q, rw_d;
  logic                   ack_phase_q, ack_phase_d;
  logic                   sda_out_q, sda_out_d;
  logic                   busy_q, busy_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_underrun_q, tx_underrun_d;

  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic                   full_q, full_d, empty_q, empty_d;
  logic                   pop_req, pop_ok, push_ok;
  logic [7:0]             pop_byte;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    scl_rise   = scl_s & ~scl_prev_q;
    scl_fall   = ~scl_s & scl_prev_q;
    start_det  = scl_s & ~sda_s & sda_prev_q;
    stop_det   = scl_s & sda_s & ~sda_prev_q;
  end

  // An empty pop yields 8'hFF; a push never bypasses into the same-cycle pop.
  assign pop_ok   = pop_req && (count_q != '0);
  assign pop_byte = (count_q != '0) ? mem_q[rd_ptr_q] : 8'hFF;
  assign push_ok  = write_enable && ((count_q != DEPTH_C) || pop_ok);

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rw_d          = rw_q;
    ack_phase_d   = ack_phase_q;
    sda_out_d     = sda_out_q;
    busy_d        = busy_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    pop_req       = 1'b0;
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_out_d = 1'b1;
    end else if (stop_det) begin
      state_d   = IDLE;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shift_q[6:0] == SLAVE_ADDR) begin
              state_d     = ADDR_ACK;
              busy_d      = 1'b1;
              rw_d        = sda_s;
              ack_phase_d = 1'b0;
            end else begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        ADDR_ACK, RX_ACK: if (scl_fall) begin
          // First falling edge pulls ACK low, second ends the ACK bit.
          if (!ack_phase_q) begin
            sda_out_d   = 1'b0;
            ack_phase_d = 1'b1;
          end else begin
            bit_cnt_d = '0;
            if (state_q == ADDR_ACK && rw_q) begin
              pop_req   = 1'b1;
              shift_d   = pop_byte;
              sda_out_d = pop_byte[7];
              state_d   = TX_BYTE;
            end else begin
              sda_out_d = 1'b1;
              state_d   = RX_BYTE;
            end
          end
        end
        RX_BYTE: if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d   = {shift_q[6:0], sda_s};
            rx_valid_d  = 1'b1;
            ack_phase_d = 1'b0;
            state_d     = RX_ACK;
          end
        end
        TX_BYTE: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_out_d   = 1'b1;
            ack_phase_d = 1'b0;
            state_d     = TX_ACK_CHK;
          end else begin
            shift_d   = {shift_q[6:0], 1'b1};
            sda_out_d = shift_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        TX_ACK_CHK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end else begin
              ack_phase_d = 1'b1;
            end
          end else if (scl_fall && ack_phase_q) begin
            pop_req   = 1'b1;
            shift_d   = pop_byte;
            sda_out_d = pop_byte[7];
            bit_cnt_d = '0;
            state_d   = TX_BYTE;
          end
        end
        default: ;
      endcase
    end
    tx_underrun_d = pop_req && (count_q == '0);
  end

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q    <= '1;
      sda_sync_q    <= '1;
      scl_prev_q    <= 1'b1;
      sda_prev_q    <= 1'b1;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rw_q          <= 1'b0;
      ack_phase_q   <= 1'b0;
      sda_out_q     <= 1'b1;
      busy_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
    end else begin
      scl_sync_q    <= scl_sync_d;
      sda_sync_q    <= sda_sync_d;
      scl_prev_q    <= scl_prev_d;
      sda_prev_q    <= sda_prev_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rw_q          <= rw_d;
      ack_phase_q   <= ack_phase_d;
      sda_out_q     <= sda_out_d;
      busy_q        <= busy_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
    end
  end

  assign sda_out     = sda_out_q;
  assign busy        = busy_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign fifo_count  = count_q;
  assign fifo_full   = full_q;
  assign fifo_empty  = empty_q;

endmodule

// File: tb/tb_i2c_slave_fifo_param.sv
// Bench for i2c_slave_fifo_param: bit-banged I2C master on a wired-AND SDA,
// queue scoreboards for received bytes and for bytes read back from the TX FIFO.
module tb_i2c_slave_fifo_param;
  localparam int         DEPTH = 4;
  localparam logic [6:0] ADDR  = 7'h78;

  logic       clk = 1'b0, rst = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       write_enable = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic       sda_in, sda_out, fifo_full, fifo_empty, rx_valid, tx_underrun, busy;
  logic [2:0] fifo_count;
  logic [7:0] rx_data;

  assign sda_in = sda_m & sda_out;

  i2c_slave_fifo_param #(.SLAVE_ADDR(ADDR), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(3)) dut (
    .clk(clk), .rst(rst), .scl(scl_m), .sda_in(sda_in), .sda_out(sda_out),
    .write_enable(write_enable), .write_data(write_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy));

  always #5 clk = ~clk;

  int         n_cmp = 0, n_err = 0;
  int         rx_cnt = 0, ur_cnt = 0;
  logic       rx_prev = 1'b0, ur_prev = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    logic       exp_ack;
  } wr_vec_t;
  wr_vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      rx_cnt++;
      check("rx_valid_width", 32'(rx_prev), 32'd0);
      if (rx_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rx_unexpected: got rx_data %0h, expected no strobe (t=%0t)", rx_data, $time);
      end else begin
        check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
      end
    end
    if (!rst && tx_underrun) begin
      ur_cnt++;
      check("underrun_width", 32'(ur_prev), 32'd0);
    end
    rx_prev = rx_valid;
    ur_prev = tx_underrun;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_cycle(input logic b, output logic r);
    clks(2); sda_m = b;
    clks(6); scl_m = 1'b1;
    clks(4); r = sda_in;
    clks(4); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      clks(2); sda_m = 1'b1;
      clks(6); scl_m = 1'b1;
    end
    clks(6); sda_m = 1'b0;
    clks(6); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    clks(2); sda_m = 1'b0;
    clks(6); scl_m = 1'b1;
    clks(6); sda_m = 1'b1;
    clks(6);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic push_on_ack,
                           input logic [7:0] pd, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], r);
    if (push_on_ack) begin write_enable = 1'b1; write_data = pd; end
    bit_cycle(1'b1, r);
    ack = ~r;
    if (push_on_ack) begin clks(6); write_enable = 1'b0; end
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin bit_cycle(1'b1, r); d[i] = r; end
    bit_cycle(ack_bit, r);
  endtask

  task automatic push(input logic [7:0] d);
    write_enable = 1'b1; write_data = d;
    clks(1);
    write_enable = 1'b0;
    if (tx_q.size() < DEPTH) tx_q.push_back(d);
  endtask

  function automatic logic [7:0] exp_tx();
    if (tx_q.size() > 0) return tx_q.pop_front();
    return 8'hFF;
  endfunction

  initial begin
    logic       ack, r;
    logic [7:0] d, first, e;
    logic [2:0] bits;
    int         exp_rx, ur0, rx0;

    vecs[0] = '{7'h78, 8'h5A, 1'b1};
    vecs[1] = '{7'h01, 8'h33, 1'b0};
    vecs[2] = '{7'h78, 8'h00, 1'b1};
    vecs[3] = '{7'h79, 8'hFF, 1'b0};
    vecs[4] = '{7'h78, 8'hFF, 1'b1};
    vecs[5] = '{7'h38, 8'h11, 1'b0};

    // Reset state
    clks(2);
    check("rst_sda_out", 32'(sda_out), 32'd1);
    check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_underrun", 32'(tx_underrun), 32'd0);
    rst = 1'b0;
    clks(4);

    // Master read of three queued bytes: ACK, ACK, NACK
    push(8'hF0); push(8'h3C); push(8'hA5);
    clks(1);
    check("rd_fifo_count", 32'(fifo_count), 32'd3);
    check("rd_fifo_empty", 32'(fifo_empty), 32'd0);
    i2c_start();
    send_byte({ADDR, 1'b1}, 1'b0, 8'h00, ack);
    check("rd_addr_ack", 32'(ack), 32'd1);
    check("rd_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      read_byte(i == 2, d);
      e = exp_tx();
      check("rd_byte", 32'(d), 32'(e));
    end
    clks(1);
    check("rd_busy_after_nack", 32'(busy), 32'd0);
    check("rd_fifo_empty_after", 32'(fifo_empty), 32'd1);
    i2c_stop();

    // Master writes from the vector table
    exp_rx = rx_cnt;
    for (int i = 0; i < 6; i++) begin
      i2c_start();
      send_byte({vecs[i].addr, 1'b0}, 1'b0, 8'h00, ack);
      check("wr_addr_ack", 32'(ack), 32'(vecs[i].exp_ack));
      if (vecs[i].exp_ack) begin
        check("wr_busy", 32'(busy), 32'd1);
        rx_q.push_back(vecs[i].data);
        exp_rx++;
      end
      send_byte(vecs[i].data, 1'b0, 8'h00, ack);
      check("wr_data_ack", 32'(ack), 32'(vecs[i].exp_ack));
      i2c_stop();
      check("wr_busy_after_stop", 32'(busy), 32'd0);
      check("wr_sda_released", 32'(sda_out), 32'd1);
    end
    check("wr_rx_count", 32'(rx_cnt), 32'(exp_rx));
    check("wr_rx_queue_drained", 32'(rx_q.size()), 32'd0);

    // Read with an empty FIFO
    ur0 = ur_cnt;
    i2c_start();
    send_byte({ADDR, 1'b1}, 1'b0, 8'h00, ack);
    check("ur_addr_ack", 32'(ack), 32'd1);
    read_byte(1'b1, d);
    e = exp_tx();
    check("ur_byte", 32'(d), 32'(e));
    check("ur_strobe_count", 32'(ur_cnt), 32'(ur0 + 1));
    check("ur_fifo_count", 32'(fifo_count), 32'd0);
    i2c_stop();

    // Overfill, then push during the pop cycle while full
    for (int i = 0; i <= DEPTH; i++) push(8'h10 + 8'(i));
    clks(1);
    check("full_flag", 32'(fifo_full), 32'd1);
    check("full_count", 32'(fifo_count), 32'(DEPTH));
    ur0 = ur_cnt;
    i2c_start();
    send_byte({ADDR, 1'b1}, 1'b1, 8'hEE, ack);
    check("full_addr_ack", 32'(ack), 32'd1);
    first = tx_q.pop_front();
    tx_q.push_back(8'hEE);
    check("full_pushpop_count", 32'(fifo_count), 32'(DEPTH));
    check("full_pushpop_flag", 32'(fifo_full), 32'd1);
    for (int i = 0; i <= DEPTH; i++) begin
      read_byte(i == DEPTH, d);
      if (i == 0) e = first;
      else e = exp_tx();
      check("full_seq_byte", 32'(d), 32'(e));
    end
    clks(1);
    check("full_drained", 32'(fifo_empty), 32'd1);
    check("full_no_underrun", 32'(ur_cnt), 32'(ur0));
    i2c_stop();

    // STOP after four data bits, then a clean write
    rx0 = rx_cnt;
    i2c_start();
    send_byte({ADDR, 1'b0}, 1'b0, 8'h00, ack);
    check("stop4_addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, r);
    i2c_stop();
    check("stop4_busy", 32'(busy), 32'd0);
    check("stop4_sda", 32'(sda_out), 32'd1);
    check("stop4_no_rx", 32'(rx_cnt), 32'(rx0));
    i2c_start();
    send_byte({ADDR, 1'b0}, 1'b0, 8'h00, ack);
    check("post_stop_addr_ack", 32'(ack), 32'd1);
    rx_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b0, 8'h00, ack);
    check("post_stop_data_ack", 32'(ack), 32'd1);
    i2c_stop();
    check("post_stop_rx", 32'(rx_cnt), 32'(rx0 + 1));

    // Reset while the slave is driving a 0 data bit
    push(8'h00);
    i2c_start();
    send_byte({ADDR, 1'b1}, 1'b0, 8'h00, ack);
    check("rstmid_addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 3; i++) bit_cycle(1'b1, r);
    clks(6);
    check("rstmid_driving_low", 32'(sda_out), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_sda_released", 32'(sda_out), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_fifo_empty", 32'(fifo_empty), 32'd1);
    rst = 1'b0;
    tx_q.delete();
    clks(2); scl_m = 1'b1;
    clks(2); sda_m = 1'b1;
    clks(10);

    // Repeated START in the middle of a read byte
    push(8'h96); push(8'h69);
    i2c_start();
    send_byte({ADDR, 1'b1}, 1'b0, 8'h00, ack);
    check("rs_addr_ack", 32'(ack), 32'd1);
    for (int i = 2; i >= 0; i--) begin bit_cycle(1'b1, r); bits[i] = r; end
    e = exp_tx();
    check("rs_partial_bits", 32'(bits), 32'(e[7:5]));
    i2c_start();
    send_byte({ADDR, 1'b0}, 1'b0, 8'h00, ack);
    check("rs_new_addr_ack", 32'(ack), 32'd1);
    check("rs_busy", 32'(busy), 32'd1);
    rx_q.push_back(8'h77);
    send_byte(8'h77, 1'b0, 8'h00, ack);
    check("rs_data_ack", 32'(ack), 32'd1);
    i2c_stop();
    check("rs_fifo_count", 32'(fifo_count), 32'(tx_q.size()));
    check("rs_rx_queue_drained", 32'(rx_q.size()), 32'd0);

    clks(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
